// File: rtl/prog_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : prog_mem_responder
//  Description : Memory-side responder for the 4-bit CPU's memory bus.
//                Holds a DEPTH x DATA_W RAM with a zero-latency read path and
//                a CPU write port. A boot-loader FSM fills the RAM from a
//                valid/ready byte stream while holding the CPU in reset, then
//                releases the CPU once loading ends.
//
//  Ports
//    clk           in   1         rising-edge clock
//    reset         in   1         synchronous, active-high reset
//    mem_address   in   ADDR_W    CPU address
//    mem_data_w    in   DATA_W    CPU write data
//    mem_we        in   1         CPU write enable (honoured only in RUN)
//    mem_data_r    out  DATA_W    ram[mem_address], combinational
//    load_start    in   1         RUN -> LOAD request
//    load_valid    in   1         loader byte valid
//    load_data     in   DATA_W    loader byte
//    load_last     in   1         final loader byte marker
//    load_ready    out  1         high only in LOAD
//    cpu_reset_n   out  1         registered active-low CPU reset
//    load_count    out  ADDR_W+1  bytes accepted in the current load
//    dbg_ld_state  out  2         LOAD=0, RELEASE=1, RUN=2
//
//  Revision    : 1.0  initial release
// ============================================================================
module prog_mem_responder #(
    parameter int ADDR_W         = 4,
    parameter int DATA_W         = 8,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] mem_address,
    input  logic [DATA_W-1:0] mem_data_w,
    input  logic              mem_we,
    output logic [DATA_W-1:0] mem_data_r,
    input  logic              load_start,
    input  logic              load_valid,
    input  logic [DATA_W-1:0] load_data,
    input  logic              load_last,
    output logic              load_ready,
    output logic              cpu_reset_n,
    output logic [ADDR_W:0]   load_count,
    output logic [1:0]        dbg_ld_state
);

    localparam int                c_DEPTH     = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] c_LAST_ADDR = '1;
    localparam logic [ADDR_W:0]   c_CNT_ONE   = {{ADDR_W{1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_LOAD    = 2'd0,
        ST_RELEASE = 2'd1,
        ST_RUN     = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [DATA_W-1:0]   r_ram [c_DEPTH];
    logic [ADDR_W:0]     r_load_count;
    logic                r_cpu_reset_n;

    logic                w_load_ready;
    logic                w_handshake;
    logic                w_load_done;
    logic                w_cpu_we;
    logic                w_restart;
    logic [ADDR_W-1:0]   w_wr_ptr;

    // The write pointer is the low bits of the byte count: a load always
    // starts at address 0 and leaves LOAD before the count can reach DEPTH.
    assign w_wr_ptr    = r_load_count[ADDR_W-1:0];
    assign w_handshake = load_valid & w_load_ready;
    // Writing the top address ends the load even without load_last, so the
    // loader can never wrap onto address 0.
    assign w_load_done = w_handshake & (load_last | (w_wr_ptr == c_LAST_ADDR));
    assign w_cpu_we    = (r_state == ST_RUN) & mem_we;
    assign w_restart   = (r_state == ST_RUN) & load_start;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_LOAD;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and decoded outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_load_ready = 1'b0;
        case (r_state)
            ST_LOAD: begin
                w_load_ready = 1'b1;
                if (w_load_done) begin
                    w_state_next = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                w_state_next = ST_RUN;
            end
            ST_RUN: begin
                if (load_start) begin
                    w_state_next = ST_LOAD;
                end
            end
            default: begin
                w_state_next = ST_LOAD;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // CPU reset: registered so it changes exactly on the edge that enters
    // or leaves RUN; RELEASE therefore gives one extra clock of reset.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cpu_reset_n <= 1'b0;
        end else begin
            r_cpu_reset_n <= (w_state_next == ST_RUN);
        end
    end

    // ------------------------------------------------------------------
    // Load byte counter: cleared on reload, frozen in RELEASE/RUN.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_load_count <= '0;
        end else if (w_restart) begin
            r_load_count <= '0;
        end else if (w_handshake) begin
            r_load_count <= r_load_count + c_CNT_ONE;
        end
    end

    // ------------------------------------------------------------------
    // RAM array. The loader and CPU write ports are mutually exclusive by
    // state, so a single prioritised write port suffices. Reset blocks
    // every write, and optionally clears the array.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            if (CLEAR_ON_RESET != 0) begin
                for (int i = 0; i < c_DEPTH; i++) begin
                    r_ram[i] <= '0;
                end
            end
        end else if (w_handshake) begin
            r_ram[w_wr_ptr] <= load_data;
        end else if (w_cpu_we) begin
            r_ram[mem_address] <= mem_data_w;
        end
    end

    assign mem_data_r   = r_ram[mem_address];
    assign load_ready   = w_load_ready;
    assign cpu_reset_n  = r_cpu_reset_n;
    assign load_count   = r_load_count;
    assign dbg_ld_state = r_state;

endmodule
`default_nettype wire
